// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// FSM encoding, common keyboard command bytes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchronizer for one raw PS/2 line plus a falling-edge pulse.
// Flops reset to 1 (idle line level) so reset release never fakes an edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= 3'b111;
    else     sh_q <= {sh_q[1:0], line_i};
  end

  // sh_q[1] is the synced level, sh_q[2] its previous value
  assign sync_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data, odd parity, stop, ACK.
// Optional watchdog from clock release to ACK sample: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          err_flag_q, err_flag_d;
  logic          ready_q, ready_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;

  logic clk_s, clk_fall, data_s, unused_data_fall;

  ps2_sync_edge u_sync_clk (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk_i),
    .sync_o (clk_s),
    .fall_o (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_data_i),
    .sync_o (data_s),
    .fall_o (unused_data_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
`else
  wire [31:0] unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    par_d      = par_q;
    err_flag_d = err_flag_q;
    data_oe_d  = data_oe_q;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          data_d     = tx_data;
          par_d      = odd_parity(tx_data);
          err_flag_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_START: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
`ifdef PS2_TX_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        // Device clock falls: present the next bit; the device samples on the rise
        if (clk_fall) begin
          if (bit_q < 4'd8) begin
            data_oe_d = ~data_q[bit_q[2:0]];
            bit_d     = bit_q + 4'd1;
          end else if (bit_q == 4'd8) begin
            data_oe_d = ~par_q;
            bit_d     = 4'd9;
          end else begin
            bit_d   = 4'd10;
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          err_flag_d = data_s;
          state_d    = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state_q == ST_SHIFT || state_q == ST_ACK) begin
      if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
        state_d    = ST_DONE;
        err_flag_d = 1'b1;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end
`endif

    // Line drivers are registered from the next state so they change with it
    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_START);
    if (state_d != ST_SHIFT) data_oe_d = (state_d == ST_START);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      err_flag_q <= 1'b0;
      ready_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      par_q      <= par_d;
      err_flag_q <= err_flag_d;
      ready_q    <= ready_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = done & err_flag_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a device-side PS/2 keyboard model.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int STC = 5;
  localparam int TMO = 400;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       dev_clk_lo = 1'b0, dev_data_lo = 1'b0;
  wire        clk_line  = ~(ps2_clk_oe | dev_clk_lo);
  wire        data_line = ~(ps2_data_oe | dev_data_lo);

  int n_pass = 0, n_tot = 0, done_cnt = 0, idle_viol = 0;
  bit idle_watch = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_CYCLES(STC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(clk_line), .ps2_data_i(data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (idle_watch && (ps2_clk_oe || ps2_data_oe || busy)) idle_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clk_line(input logic want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (clk_line === want) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  // Device receive: sense inhibit, clock in 10 bits on rising edges, then ACK pulse
  task automatic dev_rx(input bit ack, output logic [10:0] frame, output bit ok);
    bit ok1, ok2;
    frame = '0;
    wait_clk_line(1'b0, ok1);
    wait_clk_line(1'b1, ok2);
    ok = ok1 & ok2;
    if (!ok) return;
    frame[0] = data_line;
    for (int k = 1; k <= 10; k++) begin
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b0;
      frame[k] = data_line;
    end
    repeat (H) @(negedge clk);
    if (ack) dev_data_lo = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_lo = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_lo  = 1'b0;
    dev_data_lo = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output logic e);
    seen = 1'b0;
    e    = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; e = err; return; end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         ack;
    logic       err;
  } vec_t;

  initial begin
    vec_t       vecs[4];
    logic [10:0] fr;
    bit          ok, seen;
    logic        e;
    int          dc0;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hF4, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1};  // ACK withheld
    vecs[3] = '{8'hEE, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", tx_ready, 0);
    rst = 1'b0;
    chk("ready_at_release", tx_ready, 0);
    @(negedge clk);
    chk("ready_after_release", tx_ready, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      tx_data  = vecs[i].data;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("accept_ready_low", tx_ready, 0);
      chk("accept_clk_oe", ps2_clk_oe, 1);
      dev_rx(vecs[i].ack, fr, ok);
      chk("vec_dev_sync", ok, 1);
      chk("vec_start", fr[0], 0);
      chk("vec_data", fr[8:1], vecs[i].data);
      chk("vec_parity", fr[9], vecs[i].par);
      chk("vec_stop", fr[10], 1);
      wait_done(seen, e);
      chk("vec_done", seen, 1);
      chk("vec_err", e, vecs[i].err);
      @(negedge clk);
      chk("vec_ready_after", tx_ready, 1);
    end

    // Back-to-back with tx_valid held high
    @(negedge clk);
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("b2b_accept1", tx_ready, 0);
    tx_data = 8'hFF;
    dev_rx(1'b1, fr, ok);
    chk("b2b1_data", fr[8:1], 8'h07);
    chk("b2b1_parity", fr[9], 0);
    wait_done(seen, e);
    chk("b2b1_done", seen, 1);
    chk("b2b1_err", e, 0);
    chk("b2b_no_early_ready", tx_ready, 0);
    @(negedge clk);
    chk("b2b_ready_after_done", tx_ready, 1);
    chk("b2b_not_started", ps2_clk_oe, 0);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_accept2_ready", tx_ready, 0);
    chk("b2b_accept2_clk_oe", ps2_clk_oe, 1);
    dev_rx(1'b1, fr, ok);
    chk("b2b2_data", fr[8:1], 8'hFF);
    chk("b2b2_parity", fr[9], 1);
    wait_done(seen, e);
    chk("b2b2_done", seen, 1);
    chk("b2b2_err", e, 0);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int  cyc, c0, c1;
      logic prev_oe, e_to, oe_to;
      @(negedge clk);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      prev_oe = ps2_clk_oe;
      c0 = -1; c1 = -1; e_to = 1'bx; oe_to = 1'bx;
      for (cyc = 0; cyc < TMO + INH + STC + 100; cyc++) begin
        @(negedge clk);
        if (prev_oe && !ps2_clk_oe && c0 < 0) c0 = cyc;
        prev_oe = ps2_clk_oe;
        if (done) begin c1 = cyc; e_to = err; oe_to = ps2_clk_oe | ps2_data_oe; break; end
      end
      chk("to_done_seen", (c1 >= 0), 1);
      chk("to_latency", c1 - c0, TMO);
      chk("to_err", e_to, 1);
      chk("to_oe_released", oe_to, 0);
      @(negedge clk);
      chk("to_ready_after", tx_ready, 1);
    end
`endif

    // Reset during SHIFT after the 4th device clock
    @(negedge clk);
    tx_data  = 8'hF7;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_clk_line(1'b0, ok);
    wait_clk_line(1'b1, ok);
    chk("rm_released", ok, 1);
    for (int k = 1; k <= 4; k++) begin
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b1;
      if (k < 4) begin
        repeat (H) @(negedge clk);
        dev_clk_lo = 1'b0;
      end
    end
    repeat (H - 2) @(negedge clk);
    chk("rm_bit3_on_line", ps2_data_oe, 1);
    dc0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("rm_clk_oe_async", ps2_clk_oe, 0);
    chk("rm_data_oe_async", ps2_data_oe, 0);
    chk("rm_busy", busy, 0);
    repeat (2) @(negedge clk);
    dev_clk_lo = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_ready_at_release", tx_ready, 0);
    @(negedge clk);
    chk("rm_ready_after", tx_ready, 1);
    repeat (20) @(negedge clk);
    chk("rm_no_done", done_cnt - dc0, 0);

    // Device traffic while idle: scan code 0x1C
    begin
      logic [10:0] tx_fr, rx_fr;
      tx_fr = {1'b1, 1'b0, 8'h1C, 1'b0};
      rx_fr = '0;
      idle_watch = 1'b1;
      for (int k = 0; k <= 10; k++) begin
        dev_data_lo = ~tx_fr[k];
        repeat (H) @(negedge clk);
        dev_clk_lo = 1'b1;
        rx_fr[k] = data_line;
        repeat (H) @(negedge clk);
        dev_clk_lo = 1'b0;
      end
      dev_data_lo = 1'b0;
      repeat (10) @(negedge clk);
      idle_watch = 1'b0;
      chk("idle_rx_data", rx_fr[8:1], 8'h1C);
      chk("idle_rx_parity", rx_fr[9], 0);
      chk("idle_no_drive", idle_viol, 0);
      chk("idle_busy", busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte, for example 0xED (set LEDs) or 0xFF (reset), from the host to the keyboard over the shared open-drain clock and data lines. It is the opposite direction of `ps2_keyboard`, which receives device-to-host scan codes, and sits beside it on the same two wires. The block runs the full request-to-send sequence: inhibit, start bit, 8 data bits, odd parity, stop bit, then the device ACK. It reports completion or error to the host logic through a valid/ready handshake.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-low hold time before the start bit (≥100 µs at 50 MHz).
- `START_CYCLES`, default 50: data-low hold time before the clock is released.
- `TIMEOUT_CYCLES`, default 750000: watchdog limit, counted from clock release to the ACK edge.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: send request.
- `tx_ready` output 1: block is idle and can accept a byte.
- `ps2_clk_i` input 1: PS/2 clock line, raw and asynchronous.
- `ps2_data_i` input 1: PS/2 data line, raw and asynchronous.
- `ps2_clk_oe` output 1: 1 drives the clock line low, 0 releases it.
- `ps2_data_oe` output 1: 1 drives the data line low, 0 releases it.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: 1-cycle pulse at the end of each transfer.
- `err` output 1: 1-cycle pulse, coincident with `done`, when the transfer failed.

## Operation
- Both inputs pass through a 2-FF synchronizer. A falling edge means the previous synced value was 1 and the current one is 0.
- Accept: `tx_valid && tx_ready` latches `tx_data` and the odd parity bit `~^tx_data`. The FSM moves to INHIBIT.
- States and transitions:
  - IDLE: both OE = 0, `tx_ready` = 1.
  - INHIBIT: `ps2_clk_oe` = 1 for INHIBIT_CYCLES, then go to START.
  - START: `ps2_clk_oe` = 1 and `ps2_data_oe` = 1 for START_CYCLES, then go to SHIFT. On entry to SHIFT, `ps2_clk_oe` drops to 0; this is the clock release.
  - SHIFT: a 4-bit bit counter counts falling edges. Falling edges 1–8 put data bit 0..7 on the line, LSB first (`ps2_data_oe` = ~bit). Falling edge 9 puts the parity bit on the line. Falling edge 10 releases data (stop bit) and moves to ACK.
  - ACK: at the next falling edge, sample `ps2_data_i`. A 0 is a good ACK; a 1 sets the error flag. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until the synced clock and data lines are both 1, then go to DONE.
  - DONE: pulse `done`, with `err` if the error flag is set, then return to IDLE.
- Falling edges on the lines while in IDLE are ignored; device traffic belongs to `ps2_keyboard`.
- `tx_valid` is ignored while `busy`. The byte is not queued.

## Timing
- Reset values: `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `busy` = 0, `done` = 0, `err` = 0, `tx_ready` = 0.
- `tx_ready` is registered and rises on the first cycle after `rst` deasserts.
- `tx_ready` falls on the cycle after acceptance. `ps2_clk_oe` rises on that same cycle.
- Edge-to-data latency is 3 `clk` cycles (2 sync + 1 register). This is well inside the ≥5 µs low phase of the device clock.
- Counter widths are sized with `$clog2` of the parameter. Counters saturate and never wrap.
- The next byte can be accepted on the cycle after `done`.
- Reset mid-transfer: both OE go to 0 immediately (asynchronous). No `done` pulse is issued. The FSM returns to IDLE.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - The watchdog counter runs from clock release until the ACK sample.
  - Reaching TIMEOUT_CYCLES releases both lines, goes directly to DONE, and pulses `done` + `err`.
- Not defined:
  - There is no watchdog and no counter logic.
  - The block waits indefinitely for device clocks.
  - The TIMEOUT_CYCLES parameter is present but unused.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE).
  - Command constants: `PS2_CMD_SET_LED` = 8'hED, `PS2_CMD_ECHO` = 8'hEE, `PS2_CMD_ENABLE` = 8'hF4, `PS2_CMD_RESET` = 8'hFF.
  - Odd-parity function.
- Sub-module `ps2_sync_edge`: 2-FF synchronizer plus falling-edge pulse. Instantiated once each for the clock and data lines.

## Test plan
The keyboard model needs a device-side receive task: it generates clocks after sensing the inhibit, samples data on rising edges, and drives the ACK.
- Send 0xED → bits 1,0,1,1,0,1,1,1 on the line, then parity 1 and stop 1. The model ACKs, the model receives 0xED, and `done` = 1 with `err` = 0.
- Send 0x07, then 0xFF back-to-back with `tx_valid` held high → parity 0, then parity 1. The second byte is accepted only on the cycle after the first `done`.
- The model withholds the ACK (data stays high) → `done` and `err` pulse together, then `tx_ready` = 1.
- With `PS2_TX_TIMEOUT_EN` defined, the model never clocks → `err` pulses at TIMEOUT_CYCLES after clock release, and both OE = 0.
- Assert `rst` during SHIFT bit 4 → both OE = 0 in the same cycle, no `done` pulse, and `tx_ready` = 1 one cycle after release.
- The model sends scan code 0x1C while this block is idle → OE outputs stay 0, `busy` stays 0, and `ps2_keyboard` receives 0x1C.
